// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection and pipeline control for the 5-stage core.
// Compares the ID-stage source registers against the EX/MEM/WB destinations and
// drives the stop/flush controls consumed by the pc, if_id, id_ex and ex_mem
// registers, plus the operand forwarding selects.
//
// Optional feature macro: FWD_EN
//   defined   : EX > MEM > WB forwarding; only load-use stalls (one bubble)
//   undefined : no forwarding; any hit stalls 3/2/1 cycles for EX/MEM/WB
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   id_rs1/id_rs2, id_re1/id_re2     ID source registers and read enables
//   ex_/mem_/wb_wr, ex_/mem_/wb_we   per-stage destination and write enable
//   ex_rf_wesl                       EX write-back source select (load marker)
//   ex_branch_taken                  redirect from EX
//   mem_busy                         data memory not ready, freeze everything
//   pc_stop .. ex_mem_stop           hold the corresponding register
//   if_id_flush, id_ex_flush         load a bubble
//   fwd_sel1, fwd_sel2               0 regfile, 1 EX, 2 MEM, 3 WB
//   stall_cycles                     saturating count of hazard-stall cycles
module hazard_ctrl #(
  parameter logic [1:0]  LOAD_SEL = 2'b01,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       ex_wr,
  input  logic [4:0]       mem_wr,
  input  logic [4:0]       wb_wr,
  input  logic             ex_we,
  input  logic             mem_we,
  input  logic             wb_we,
  input  logic [1:0]       ex_rf_wesl,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_stop,
  output logic             if_id_stop,
  output logic             id_ex_stop,
  output logic             ex_mem_stop,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [1:0]         stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic hit_ex1, hit_mem1, hit_wb1;
  logic hit_ex2, hit_mem2, hit_wb2;
  logic [1:0] fsel1_c, fsel2_c;
  logic [1:0] need_n_c;   // required stall length, 0 = no hazard

  // Register hits; x0 never hazards
  assign hit_ex1  = id_re1 & ex_we  & (ex_wr  != 5'd0) & (ex_wr  == id_rs1);
  assign hit_mem1 = id_re1 & mem_we & (mem_wr != 5'd0) & (mem_wr == id_rs1);
  assign hit_wb1  = id_re1 & wb_we  & (wb_wr  != 5'd0) & (wb_wr  == id_rs1);
  assign hit_ex2  = id_re2 & ex_we  & (ex_wr  != 5'd0) & (ex_wr  == id_rs2);
  assign hit_mem2 = id_re2 & mem_we & (mem_wr != 5'd0) & (mem_wr == id_rs2);
  assign hit_wb2  = id_re2 & wb_we  & (wb_wr  != 5'd0) & (wb_wr  == id_rs2);

`ifdef FWD_EN
  // Nearest producer wins; only a load in EX cannot be forwarded yet
  always_comb begin
    fsel1_c  = hit_ex1 ? 2'd1 : hit_mem1 ? 2'd2 : hit_wb1 ? 2'd3 : 2'd0;
    fsel2_c  = hit_ex2 ? 2'd1 : hit_mem2 ? 2'd2 : hit_wb2 ? 2'd3 : 2'd0;
    need_n_c = ((hit_ex1 | hit_ex2) && (ex_rf_wesl == LOAD_SEL)) ? 2'd1 : 2'd0;
  end
`else
  logic [1:0] n1_c, n2_c;
  logic       unused_wesl;
  assign unused_wesl = ^{ex_rf_wesl, LOAD_SEL};

  // Wait until the nearest producer has retired through WB; worst operand wins
  always_comb begin
    fsel1_c  = 2'd0;
    fsel2_c  = 2'd0;
    n1_c     = hit_ex1 ? 2'd3 : hit_mem1 ? 2'd2 : hit_wb1 ? 2'd1 : 2'd0;
    n2_c     = hit_ex2 ? 2'd3 : hit_mem2 ? 2'd2 : hit_wb2 ? 2'd1 : 2'd0;
    need_n_c = (n1_c > n2_c) ? n1_c : n2_c;
  end
`endif

  logic pc_stop_c, if_id_stop_c, id_ex_stop_c, ex_mem_stop_c;
  logic if_id_flush_c, id_ex_flush_c;
  logic stall_c;

  // Next state and Mealy controls: busy > redirect > stall
  always_comb begin
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    pc_stop_c      = 1'b0;
    if_id_stop_c   = 1'b0;
    id_ex_stop_c   = 1'b0;
    ex_mem_stop_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    stall_c        = 1'b0;

    if (mem_busy) begin
      pc_stop_c     = 1'b1;
      if_id_stop_c  = 1'b1;
      id_ex_stop_c  = 1'b1;
      ex_mem_stop_c = 1'b1;
    end else if (ex_branch_taken) begin
      // Redirect kills the stalled ID instruction as well
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
      state_d       = RUN;
      stall_cnt_d   = 2'd0;
    end else if (state_q == STALL) begin
      stall_c     = 1'b1;
      stall_cnt_d = stall_cnt_q - 2'd1;
      if (stall_cnt_q <= 2'd1) begin
        state_d     = RUN;
        stall_cnt_d = 2'd0;
      end
    end else if (need_n_c != 2'd0) begin
      stall_c     = 1'b1;
      stall_cnt_d = need_n_c - 2'd1;
      state_d     = (need_n_c > 2'd1) ? STALL : RUN;
    end

    if (stall_c) begin
      pc_stop_c     = 1'b1;
      if_id_stop_c  = 1'b1;
      id_ex_flush_c = 1'b1;
    end
  end

  // Saturating performance counter
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_c && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      stall_cnt_q    <= 2'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cnt_q    <= stall_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Reset forces all controls inactive immediately
  assign pc_stop      = rst_n & pc_stop_c;
  assign if_id_stop   = rst_n & if_id_stop_c;
  assign id_ex_stop   = rst_n & id_ex_stop_c;
  assign ex_mem_stop  = rst_n & ex_mem_stop_c;
  assign if_id_flush  = rst_n & if_id_flush_c;
  assign id_ex_flush  = rst_n & id_ex_flush_c;
  assign fwd_sel1     = rst_n ? fsel1_c : 2'd0;
  assign fwd_sel2     = rst_n ? fsel2_c : 2'd0;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus random stimulus against a cycle-level
// reference model of the hazard unit (remaining-stall counter, nearest-producer search).
module tb_hazard_ctrl;
  localparam int unsigned CNT_W    = 32;
  localparam logic [1:0]  LOAD_SEL = 2'b01;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_wr, mem_wr, wb_wr;
  logic id_re1, id_re2, ex_we, mem_we, wb_we;
  logic [1:0] ex_rf_wesl;
  logic ex_branch_taken, mem_busy;
  logic pc_stop, if_id_stop, id_ex_stop, ex_mem_stop, if_id_flush, id_ex_flush;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_SEL(LOAD_SEL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
    .ex_rf_wesl(ex_rf_wesl), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_stop(pc_stop), .if_id_stop(if_id_stop), .id_ex_stop(id_ex_stop),
    .ex_mem_stop(ex_mem_stop), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cycles(stall_cycles)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: stall cycles still owed after the current one, and the counter
  int     m_left;
  longint m_cnt;

  function automatic bit hit(input int k, input int s);
    logic [4:0] rs, wr;
    bit re, we;
    rs = (k == 0) ? id_rs1 : id_rs2;
    re = (k == 0) ? id_re1 : id_re2;
    case (s)
      0:       begin wr = ex_wr;  we = ex_we;  end
      1:       begin wr = mem_wr; we = mem_we; end
      default: begin wr = wb_wr;  we = wb_we;  end
    endcase
    return re && we && (wr != 5'd0) && (wr == rs);
  endfunction

  // Distance to the nearest producing stage (0 = EX .. 2 = WB), 3 = none
  function automatic int nearest(input int k);
    for (int s = 0; s < 3; s++) if (hit(k, s)) return s;
    return 3;
  endfunction

  // One cycle: inputs already applied at posedge+1; check mid-cycle, clock, update model
  task automatic step();
    int n, e_f1, e_f2, d0, d1;
    logic [3:0] e_stop;
    logic [1:0] e_flush;
    bit stalling;
    d0 = nearest(0);
    d1 = nearest(1);
`ifdef FWD_EN
    e_f1 = (d0 == 3) ? 0 : d0 + 1;
    e_f2 = (d1 == 3) ? 0 : d1 + 1;
    n = ((d0 == 0 || d1 == 0) && ex_rf_wesl == LOAD_SEL) ? 1 : 0;
`else
    e_f1 = 0;
    e_f2 = 0;
    n = ((3 - d0) > (3 - d1)) ? (3 - d0) : (3 - d1);
`endif
    stalling = 1'b0;
    if (mem_busy) begin
      e_stop = 4'hF; e_flush = 2'b00;
    end else if (ex_branch_taken) begin
      e_stop = 4'h0; e_flush = 2'b11;
    end else if (m_left > 0 || n > 0) begin
      e_stop = 4'b1100; e_flush = 2'b01; stalling = 1'b1;
    end else begin
      e_stop = 4'h0; e_flush = 2'b00;
    end
    #4;
    check("stops", 64'({pc_stop, if_id_stop, id_ex_stop, ex_mem_stop}), 64'(e_stop));
    check("flush", 64'({if_id_flush, id_ex_flush}), 64'(e_flush));
    check("fwd_sel1", 64'(fwd_sel1), 64'(e_f1));
    check("fwd_sel2", 64'(fwd_sel2), 64'(e_f2));
    @(posedge clk);
    #1;
    if (!mem_busy) begin
      if (ex_branch_taken) m_left = 0;
      else if (m_left > 0) m_left--;
      else if (n > 0) m_left = n - 1;
      if (stalling && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end
    check("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic re1, input logic [4:0] rs2,
                        input logic re2, input logic [4:0] exw, input logic exe,
                        input logic [4:0] memw, input logic meme, input logic [4:0] wbw,
                        input logic wbe, input logic [1:0] wesl, input logic br,
                        input logic busy);
    id_rs1 = rs1; id_re1 = re1; id_rs2 = rs2; id_re2 = re2;
    ex_wr = exw; ex_we = exe; mem_wr = memw; mem_we = meme; wb_wr = wbw; wb_we = wbe;
    ex_rf_wesl = wesl; ex_branch_taken = br; mem_busy = busy;
  endtask

  task automatic idle();
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    m_left = 0;
    m_cnt  = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stops", 64'({pc_stop, if_id_stop, id_ex_stop, ex_mem_stop,
                              if_id_flush, id_ex_flush}), 64'd0);
    check("reset_cnt", 64'(stall_cycles), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use on rs1, then the load sits in MEM
    set_in(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, LOAD_SEL, 1'b0, 1'b0);
    step();
    set_in(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    idle(); step(); step(); step();

    // Forwarding priority chain on rs2 (non-load producer)
    set_in(5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 2'b00, 1'b0, 1'b0);
    step();
    ex_we = 1'b0;  step();
    mem_we = 1'b0; step();
    set_in(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0);
    step();
    idle(); step(); step(); step();

    // Producer walks EX -> MEM -> WB -> retired
    set_in(5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    set_in(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    set_in(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0);
    step();
    set_in(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    step();

    // Redirect on the first cycle of a would-be stall
    set_in(5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0);
    step();
    idle(); step(); step();

    // mem_busy freeze in the middle of a stall
    set_in(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    idle(); step();
    mem_busy = 1'b1;
    repeat (4) step();
    mem_busy = 1'b0;
    step(); step(); step();

    // Asynchronous reset in the middle of a stall
    set_in(5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    mem_busy = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_stops", 64'({pc_stop, if_id_stop, id_ex_stop, ex_mem_stop,
                                  if_id_flush, id_ex_flush}), 64'd0);
    check("async_rst_cnt", 64'(stall_cycles), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_left = 0;
    m_cnt  = 0;
    idle();
    step();

    // Random traffic over a small register window to make hits common
    for (int i = 0; i < 1500; i++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_re1 = 1'($urandom_range(0, 1));
      id_rs2 = 5'($urandom_range(0, 3)); id_re2 = 1'($urandom_range(0, 1));
      ex_wr  = 5'($urandom_range(0, 3)); ex_we  = 1'($urandom_range(0, 1));
      mem_wr = 5'($urandom_range(0, 3)); mem_we = 1'($urandom_range(0, 1));
      wb_wr  = 5'($urandom_range(0, 3)); wb_we  = 1'($urandom_range(0, 1));
      ex_rf_wesl      = 2'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      mem_busy        = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
